// File: rtl/divider_seq_n.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's complement operands.
module subtractor_n #(
   parameter int nb_bit = 8
) (
   input  logic [nb_bit-1:0] a_i,
   input  logic [nb_bit-1:0] b_i,
   output logic [nb_bit-1:0] diff_o,
   output logic              borrow_o
);

   assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

module divider_seq_n #(
   parameter int nb_bit = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [nb_bit-1:0] dividend_i,
   input  logic [nb_bit-1:0] divisor_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [nb_bit-1:0] quotient_o,
   output logic [nb_bit-1:0] remainder_o,
   output logic              div_by_zero_o
);

   localparam int CW = (nb_bit > 2) ? $clog2(nb_bit) : 1;
   localparam logic [CW-1:0] LAST = CW'(nb_bit - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [nb_bit-1:0] r_q, r_d;
   logic [nb_bit-1:0] q_q, q_d;
   logic [nb_bit-1:0] dvs_q, dvs_d;
   logic [nb_bit-1:0] quot_q, quot_d;
   logic [nb_bit-1:0] rem_q, rem_d;
   logic              dbz_q, dbz_d;

   logic [nb_bit:0]   tmp;
   logic [nb_bit:0]   diff;
   logic              borrow;
   logic              diff_unused;
   logic [nb_bit-1:0] r_iter, q_iter;
   logic [nb_bit-1:0] a_mag, b_mag;
   logic [nb_bit-1:0] quot_fin, rem_fin;

   assign tmp = {r_q, q_q[nb_bit-1]};

   subtractor_n #(.nb_bit(nb_bit+1)) u_sub (
      .a_i      (tmp),
      .b_i      ({1'b0, dvs_q}),
      .diff_o   (diff),
      .borrow_o (borrow)
   );

   // diff MSB is always 0 when no borrow, so only the low bits matter
   assign diff_unused = diff[nb_bit];
   assign r_iter = borrow ? tmp[nb_bit-1:0] : diff[nb_bit-1:0];
   assign q_iter = {q_q[nb_bit-2:0], ~borrow};

`ifdef DIVIDER_SIGNED_EN
   logic sq_q, sq_d;
   logic sr_q, sr_d;

   assign a_mag = dividend_i[nb_bit-1] ? {nb_bit{1'b0}} - dividend_i
                                       : dividend_i;
   assign b_mag = divisor_i[nb_bit-1] ? {nb_bit{1'b0}} - divisor_i
                                      : divisor_i;
   assign quot_fin = sq_q ? {nb_bit{1'b0}} - q_iter : q_iter;
   assign rem_fin  = sr_q ? {nb_bit{1'b0}} - r_iter : r_iter;

   always_comb begin
      sq_d = sq_q;
      sr_d = sr_q;
      if (state_q == IDLE && start_i) begin
         sq_d = dividend_i[nb_bit-1] ^ divisor_i[nb_bit-1];
         sr_d = dividend_i[nb_bit-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sq_q <= 1'b0;
         sr_q <= 1'b0;
      end else begin
         sq_q <= sq_d;
         sr_q <= sr_d;
      end
   end
`else
   assign a_mag    = dividend_i;
   assign b_mag    = divisor_i;
   assign quot_fin = q_iter;
   assign rem_fin  = r_iter;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               r_d   = '0;
               cnt_d = '0;
               dbz_d = 1'b0;
               dvs_d = b_mag;
               if (divisor_i == '0) begin
                  q_d     = dividend_i;
                  quot_d  = '1;
                  rem_d   = dividend_i;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  q_d     = a_mag;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            r_d   = r_iter;
            q_d   = q_iter;
            cnt_d = cnt_q + CW'(1);
            // results registered on the last step so they show during DONE
            if (cnt_q == LAST) begin
               quot_d  = quot_fin;
               rem_d   = rem_fin;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy_o        = (state_q == CALC);
   assign done_o        = (state_q == DONE);
   assign quotient_o    = quot_q;
   assign remainder_o   = rem_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divider_seq_n.sv
// Directed bench for divider_seq_n (nb_bit = 8).
// Signed vectors run when DIVIDER_SIGNED_EN is defined.
module tb_divider_seq_n;

   localparam int NB = 8;

   logic          clk;
   logic          rst;
   logic          start;
   logic [NB-1:0] dvd;
   logic [NB-1:0] dvs;
   logic          busy;
   logic          done;
   logic [NB-1:0] quot;
   logic [NB-1:0] rem;
   logic          dbz;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;
   int cnt;

   divider_seq_n #(.nb_bit(NB)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .dividend_i    (dvd),
      .divisor_i     (dvs),
      .busy_o        (busy),
      .done_o        (done),
      .quotient_o    (quot),
      .remainder_o   (rem),
      .div_by_zero_o (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // start at current cycle T, return cycle offset of done_o (bounded)
   task automatic run(input logic [NB-1:0] a, input logic [NB-1:0] b,
                      output int l);
      dvd   = a;
      dvs   = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      l = 1;
      while (!done && l < 40) begin
         tick();
         l++;
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      dvd   = '0;
      dvs   = '0;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quot, 0);
      chk("rst_r", rem, 0);
      chk("rst_dbz", dbz, 0);
      rst = 1'b0;
      tick();

      // 1: 100/7 with exact busy/done timing
      dvd   = 8'd100;
      dvs   = 8'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 0;
      for (int i = 1; i <= NB; i++) begin
         if (busy !== 1'b1 || done !== 1'b0) cnt++;
         tick();
      end
      chk("t1_busy_window_errs", cnt, 0);
      chk("t1_done", done, 1);
      chk("t1_busy_in_done", busy, 0);
      chk("t1_q", quot, 14);
      chk("t1_r", rem, 2);
      chk("t1_dbz", dbz, 0);
      tick();
      chk("t1_done_pulse", done, 0);
      chk("t1_q_held", quot, 14);

      // 2: 255/1 then 3/200 with start held from the DONE cycle
      run(8'd255, 8'd1, lat);
      chk("t2a_lat", lat, 9);
`ifdef DIVIDER_SIGNED_EN
      chk("t2a_q", quot, 8'hFF);
`else
      chk("t2a_q", quot, 255);
`endif
      chk("t2a_r", rem, 0);
      dvd   = 8'd3;
      dvs   = 8'd200;
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      cnt = 2;
      chk("t2_q_held_calc", quot, 8'hFF);
      chk("t2_busy", busy, 1);
      while (!done && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("t2b_lat_from_done", cnt, 10);
      chk("t2b_q", quot, 0);
      chk("t2b_r", rem, 3);
      tick();

      // 3: divide by zero, then a normal op clears the flag
      run(8'd5, 8'd0, lat);
      chk("t3_lat", lat, 1);
      chk("t3_dbz", dbz, 1);
      chk("t3_q", quot, 8'hFF);
      chk("t3_r", rem, 5);
      tick();
      chk("t3_dbz_held", dbz, 1);
      run(8'd9, 8'd3, lat);
      chk("t3b_lat", lat, 9);
      chk("t3b_q", quot, 3);
      chk("t3b_r", rem, 0);
      chk("t3b_dbz", dbz, 0);
      tick();

      // 4: start during CALC is ignored
      dvd   = 8'd200;
      dvs   = 8'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      dvd   = 8'd50;
      dvs   = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 4;
      while (!done && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("t4_lat", cnt, 9);
`ifdef DIVIDER_SIGNED_EN
      chk("t4_q", quot, 8'hFA);
      chk("t4_r", rem, 8'hFE);
`else
      chk("t4_q", quot, 22);
      chk("t4_r", rem, 2);
`endif
      lat = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (done) lat++;
      end
      chk("t4_extra_done", lat, 0);

      // 5: reset mid-operation
      dvd   = 8'd100;
      dvs   = 8'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_q", quot, 0);
      chk("t5_r", rem, 0);
      chk("t5_dbz", dbz, 0);
      lat = 0;
      for (int i = 0; i < 14; i++) begin
         if (done || busy) lat++;
         tick();
      end
      chk("t5_no_done", lat, 0);
      run(8'd100, 8'd7, lat);
      chk("t5b_lat", lat, 9);
      chk("t5b_q", quot, 14);
      chk("t5b_r", rem, 2);
      tick();

      run(8'd250, 8'd16, lat);
      chk("t7_lat", lat, 9);
`ifdef DIVIDER_SIGNED_EN
      chk("t7_q", quot, 0);
      chk("t7_r", rem, 8'hFA);
`else
      chk("t7_q", quot, 15);
      chk("t7_r", rem, 10);
`endif
      tick();

`ifdef DIVIDER_SIGNED_EN
      // 6: signed vectors
      run(8'h9C, 8'd7, lat);
      chk("t6a_q", quot, 8'hF2);
      chk("t6a_r", rem, 8'hFE);
      tick();
      run(8'h80, 8'hFF, lat);
      chk("t6b_q", quot, 8'h80);
      chk("t6b_r", rem, 0);
      tick();
      run(8'd7, 8'hFE, lat);
      chk("t6c_lat", lat, 9);
      chk("t6c_q", quot, 8'hFD);
      chk("t6c_r", rem, 1);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
